// File: rtl/apu_pkg.sv
// Shared constants and register layouts for the APU master-control block.
package apu_pkg;

  localparam logic [15:0] ADDR_NR50 = 16'hFF24;
  localparam logic [15:0] ADDR_NR51 = 16'hFF25;
  localparam logic [15:0] ADDR_NR52 = 16'hFF26;
  localparam logic [15:0] ADDR_FF60 = 16'hFF60;

  // Bits 6:4 of NR52 are unimplemented and always read back as ones.
  localparam logic [7:0] NR52_RD_MASK = 8'h70;

  typedef struct packed {
    logic       vin_l;
    logic [2:0] lvol;
    logic       vin_r;
    logic [2:0] rvol;
  } nr50_t;

endpackage

// File: rtl/apu_clk_div.sv
// Power-gated divide-by-two producing the 2 MHz channel clock enable.
module apu_clk_div (
  input  logic clk,
  input  logic reset,
  input  logic power,
  output logic apu_2mhz_en
);

  logic toggle;

  // Held at zero while unpowered so the first pulse lands on the 2nd powered cycle.
  always_ff @(posedge clk) begin
    if (reset || !power) toggle <= 1'b0;
    else                 toggle <= ~toggle;
  end

  assign apu_2mhz_en = toggle & power;

endmodule

// File: rtl/apu_control_regs.sv
// DMG APU master control: NR50/NR51/NR52 registers, power reset, mixer enables.
// Optional FF60 test register enabled by defining APU_FF60_TEST_EN.
module apu_control_regs
  import apu_pkg::*;
#(
  parameter logic RESET_POWER = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] a,
  input  logic [7:0]  d_in,
  input  logic        cpu_wr,
  input  logic        cpu_rd,
  input  logic        nch1_active,
  input  logic        nch2_active,
  input  logic        nch3_active,
  input  logic        nch4_active,
  output logic [7:0]  d_out,
  output logic        d_oe,
  output logic        apu_reset,
  output logic        napu_reset,
  output logic        namp_en,
  output logic [3:0]  lmixer,
  output logic [3:0]  rmixer,
  output logic [2:0]  lvol,
  output logic [2:0]  rvol,
  output logic        vin_l,
  output logic        vin_r,
  output logic        apu_2mhz_en,
  output logic        ff60_d0,
  output logic        ff60_d1
);

  nr50_t      nr50;
  logic [7:0] nr51;
  logic       power;
  logic [3:0] ch_status;

  // Powering down wipes NR50/NR51 on the same edge; registers are frozen while off.
  always_ff @(posedge clk) begin
    if (reset) begin
      nr50  <= '0;
      nr51  <= '0;
      power <= RESET_POWER;
    end else if (cpu_wr) begin
      if (a == ADDR_NR52) begin
        power <= d_in[7];
        if (!d_in[7]) begin
          nr50 <= '0;
          nr51 <= '0;
        end
      end else if (power && a == ADDR_NR50) begin
        nr50 <= nr50_t'(d_in);
      end else if (power && a == ADDR_NR51) begin
        nr51 <= d_in;
      end
    end
  end

`ifdef APU_FF60_TEST_EN
  logic [1:0] ff60;

  always_ff @(posedge clk) begin
    if (reset)                          ff60 <= 2'b00;
    else if (cpu_wr && a == ADDR_FF60)  ff60 <= d_in[1:0];
  end

  assign ff60_d0 = ff60[0];
  assign ff60_d1 = ff60[1];
`else
  assign ff60_d0 = 1'b0;
  assign ff60_d1 = 1'b0;
`endif

  apu_clk_div u_clk_div (
    .clk         (clk),
    .reset       (reset),
    .power       (power),
    .apu_2mhz_en (apu_2mhz_en)
  );

  assign ch_status = power ? ~{nch4_active, nch3_active, nch2_active, nch1_active} : 4'b0000;

  always_comb begin
    d_out = 8'hFF;
    d_oe  = 1'b0;
    if (cpu_rd) begin
      unique case (a)
        ADDR_NR50: begin d_oe = 1'b1; d_out = nr50; end
        ADDR_NR51: begin d_oe = 1'b1; d_out = nr51; end
        ADDR_NR52: begin d_oe = 1'b1; d_out = NR52_RD_MASK | {power, 3'b000, ch_status}; end
`ifdef APU_FF60_TEST_EN
        ADDR_FF60: begin d_oe = 1'b1; d_out = {6'b111111, ff60}; end
`endif
        default: ;
      endcase
    end
  end

  assign apu_reset  = ~power;
  assign napu_reset = power;
  assign namp_en    = ~power;
  assign lmixer     = power ? nr51[7:4] : 4'b0000;
  assign rmixer     = power ? nr51[3:0] : 4'b0000;
  assign lvol       = nr50.lvol;
  assign rvol       = nr50.rvol;
  assign vin_l      = nr50.vin_l;
  assign vin_r      = nr50.vin_r;

endmodule

// File: tb/tb_apu_control_regs.sv
// Directed bench for apu_control_regs; FF60 steps follow APU_FF60_TEST_EN.
module tb_apu_control_regs;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] a;
  logic [7:0]  d_in;
  logic        cpu_wr, cpu_rd;
  logic        nch1_active, nch2_active, nch3_active, nch4_active;
  logic [7:0]  d_out;
  logic        d_oe, apu_reset, napu_reset, namp_en;
  logic [3:0]  lmixer, rmixer;
  logic [2:0]  lvol, rvol;
  logic        vin_l, vin_r, apu_2mhz_en, ff60_d0, ff60_d1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  apu_control_regs dut (
    .clk(clk), .reset(reset), .a(a), .d_in(d_in), .cpu_wr(cpu_wr), .cpu_rd(cpu_rd),
    .nch1_active(nch1_active), .nch2_active(nch2_active),
    .nch3_active(nch3_active), .nch4_active(nch4_active),
    .d_out(d_out), .d_oe(d_oe), .apu_reset(apu_reset), .napu_reset(napu_reset),
    .namp_en(namp_en), .lmixer(lmixer), .rmixer(rmixer), .lvol(lvol), .rvol(rvol),
    .vin_l(vin_l), .vin_r(vin_r), .apu_2mhz_en(apu_2mhz_en),
    .ff60_d0(ff60_d0), .ff60_d1(ff60_d1)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [15:0] addr, input logic [7:0] data);
    @(negedge clk);
    a = addr; d_in = data; cpu_wr = 1'b1; cpu_rd = 1'b0;
    @(negedge clk);
    cpu_wr = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [15:0] addr, input logic [7:0] exp_d,
                    input logic exp_oe);
    @(negedge clk);
    a = addr; cpu_rd = 1'b1;
    #1;
    check({tag, "_d"}, d_out, exp_d);
    check({tag, "_oe"}, {7'd0, d_oe}, {7'd0, exp_oe});
    cpu_rd = 1'b0;
  endtask

  initial begin
    reset = 1'b1; a = 16'h0000; d_in = 8'h00; cpu_wr = 1'b0; cpu_rd = 1'b0;
    {nch4_active, nch3_active, nch2_active, nch1_active} = 4'b1111;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset state: unpowered
    rd("rst_nr52", 16'hFF26, 8'h70, 1'b1);
    check("rst_apu_reset", {7'd0, apu_reset}, 8'd1);
    check("rst_napu_reset", {7'd0, napu_reset}, 8'd0);
    check("rst_namp_en", {7'd0, namp_en}, 8'd1);
    check("rst_lmixer", {4'd0, lmixer}, 8'h0);
    rd("rst_nr50", 16'hFF24, 8'h00, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_2mhz_idle", {7'd0, apu_2mhz_en}, 8'd0);
    end

    // Power on; divider pulses on the 2nd cycle then every other cycle
    wr(16'hFF26, 8'h80);
    check("on_apu_reset", {7'd0, apu_reset}, 8'd0);
    check("on_namp_en", {7'd0, namp_en}, 8'd0);
    check("on_2mhz_c1", {7'd0, apu_2mhz_en}, 8'd0);
    @(negedge clk); check("on_2mhz_c2", {7'd0, apu_2mhz_en}, 8'd1);
    @(negedge clk); check("on_2mhz_c3", {7'd0, apu_2mhz_en}, 8'd0);
    @(negedge clk); check("on_2mhz_c4", {7'd0, apu_2mhz_en}, 8'd1);
    rd("on_nr52", 16'hFF26, 8'hF0, 1'b1);

    // Volume and panning
    wr(16'hFF24, 8'h77);
    wr(16'hFF25, 8'hF3);
    check("lvol", {5'd0, lvol}, 8'd7);
    check("rvol", {5'd0, rvol}, 8'd7);
    check("vin_l", {7'd0, vin_l}, 8'd0);
    check("vin_r", {7'd0, vin_r}, 8'd0);
    check("lmixer", {4'd0, lmixer}, 8'h0F);
    check("rmixer", {4'd0, rmixer}, 8'h03);
    rd("rd_nr50", 16'hFF24, 8'h77, 1'b1);
    rd("rd_nr51", 16'hFF25, 8'hF3, 1'b1);
    wr(16'hFF24, 8'h88);
    check("vin_l_set", {7'd0, vin_l}, 8'd1);
    check("vin_r_set", {7'd0, vin_r}, 8'd1);
    check("lvol_zero", {5'd0, lvol}, 8'd0);
    wr(16'hFF24, 8'h77);

    // Writes to undecoded neighbours leave registers alone
    wr(16'hFF27, 8'h00);
    wr(16'hFF23, 8'h00);
    rd("nbr_nr51", 16'hFF25, 8'hF3, 1'b1);
    rd("nbr_nr52", 16'hFF26, 8'hF0, 1'b1);

    // Channel status while powered
    nch1_active = 1'b0; nch3_active = 1'b0;
    rd("status_f5", 16'hFF26, 8'hF5, 1'b1);
    nch2_active = 1'b0; nch4_active = 1'b0; nch1_active = 1'b1;
    rd("status_fe", 16'hFF26, 8'hFE, 1'b1);

    // Power off clears registers, blocks writes, masks status
    wr(16'hFF26, 8'h00);
    check("off_apu_reset", {7'd0, apu_reset}, 8'd1);
    check("off_napu_reset", {7'd0, napu_reset}, 8'd0);
    check("off_lmixer", {4'd0, lmixer}, 8'h0);
    check("off_rmixer", {4'd0, rmixer}, 8'h0);
    check("off_lvol", {5'd0, lvol}, 8'd0);
    check("off_2mhz", {7'd0, apu_2mhz_en}, 8'd0);
    rd("off_nr50", 16'hFF24, 8'h00, 1'b1);
    rd("off_nr51", 16'hFF25, 8'h00, 1'b1);
    rd("off_status", 16'hFF26, 8'h70, 1'b1);
    wr(16'hFF25, 8'hFF);
    wr(16'hFF24, 8'h55);
    rd("off_wr_nr51", 16'hFF25, 8'h00, 1'b1);
    rd("off_wr_nr50", 16'hFF24, 8'h00, 1'b1);
    {nch4_active, nch3_active, nch2_active, nch1_active} = 4'b1111;

    // Power back on: registers stay zero until rewritten
    wr(16'hFF26, 8'h80);
    rd("reon_nr50", 16'hFF24, 8'h00, 1'b1);
    check("reon_lmixer", {4'd0, lmixer}, 8'h0);

    // Address decode and read strobe
    rd("rd_ff27", 16'hFF27, 8'hFF, 1'b0);
    rd("rd_ff23", 16'hFF23, 8'hFF, 1'b0);
    @(negedge clk);
    a = 16'hFF24; cpu_rd = 1'b0; #1;
    check("nord_oe", {7'd0, d_oe}, 8'd0);
    check("nord_d", d_out, 8'hFF);

    // Reset wins over a concurrent power-on write
    wr(16'hFF26, 8'h00);
    @(negedge clk);
    a = 16'hFF26; d_in = 8'h80; cpu_wr = 1'b1; reset = 1'b1;
    @(negedge clk);
    cpu_wr = 1'b0; reset = 1'b0;
    check("rst_prec_apu_reset", {7'd0, apu_reset}, 8'd1);
    wr(16'hFF26, 8'h80);
    wr(16'hFF25, 8'hA5);
    @(negedge clk);
    a = 16'hFF26; d_in = 8'h80; cpu_wr = 1'b1; reset = 1'b1;
    @(negedge clk);
    cpu_wr = 1'b0; reset = 1'b0;
    check("rst_prec_power", {7'd0, apu_reset}, 8'd1);
    rd("rst_prec_nr51", 16'hFF25, 8'h00, 1'b1);

    // Optional test register
`ifdef APU_FF60_TEST_EN
    wr(16'hFF60, 8'h02);
    check("ff60_d1", {7'd0, ff60_d1}, 8'd1);
    check("ff60_d0", {7'd0, ff60_d0}, 8'd0);
    rd("ff60_rd", 16'hFF60, 8'hFE, 1'b1);
    wr(16'hFF60, 8'h01);
    rd("ff60_rd2", 16'hFF60, 8'hFD, 1'b1);
`else
    wr(16'hFF60, 8'h03);
    rd("ff60_nodec", 16'hFF60, 8'hFF, 1'b0);
    check("ff60_d0_off", {7'd0, ff60_d0}, 8'd0);
    check("ff60_d1_off", {7'd0, ff60_d1}, 8'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
